io_responder: RTL and testbench
===============================

Name: io_responder

Overview:
- Peripheral-side responder for the CPU's memory-mapped IO bus.
- Consumes the LED write chip-select, the switch read chip-select, the low address byte and the write data produced by the CPU's memory/IO bridge.
- Drives the 24 board LEDs from write-only registers.
- Debounces the 24 board switches and returns 16-bit read data to the bridge, plus a sticky change-status flag.

Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required before a switch change is accepted (range 1 to 2^20-1).
- LED_RESET, 24'h000000: LED register value after reset.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- LEDCtrl  input  1  LED chip select (write strobe), active high.
- SwitchCtrl  input  1  switch chip select (read strobe), active high.
- addr  input  8  low byte of the CPU data address.
- write_data  input  32  data from the register file; only bits [15:0] are used.
- switch_i  input  24  raw asynchronous switch inputs.
- led_o  output  24  LED drive, registered.
- io_rdata  output  16  read data to the bridge, combinational from registers.

Behaviour:
Address map (addr byte, base 0xFFFFFC00):
- 0x60: LED[15:0], write.
- 0x62: LED[23:16] from write_data[7:0], write; write_data[15:8] ignored.
- 0x70: switch[15:0], read.
- 0x72: {8'h00, switch[23:16]}, read.
- 0x74: status {15'b0, chg}, read; clear-on-read.
- Any other address: write ignored, read returns 16'h0000.

Reset (reset_n=0, asynchronous):
- led_o=LED_RESET.
- Synchronizer flops, stable switch vector, candidate vector and debounce counter = 0.
- chg=0.
- io_rdata follows the reset register values, so a 0x70 read during reset returns 0.

LED writes:
- Occur on a rising edge when LEDCtrl=1; zero latency to led_o after that edge.
- Writing 0x60 touches only bits [15:0]; writing 0x62 touches only bits [23:16].
- LEDCtrl=1 with SwitchCtrl=1 in the same cycle: the write happens and io_rdata still reflects the read address.

Switch path:
- 2-flop synchronizer on switch_i, giving sync.
- Debounce FSM with states IDLE and COUNT:
  - IDLE: if sync != stable, then cand<=sync, cnt<=1, go to COUNT.
  - COUNT, sync != cand: cand<=sync, cnt<=1, stay in COUNT (restart).
  - COUNT, sync == stable: return to IDLE, cnt<=0 (bounce back, no update).
  - COUNT, sync == cand and cnt == DEBOUNCE_CYCLES-1: stable<=cand, chg<=1, go to IDLE.
  - COUNT, sync == cand, below the limit: cnt<=cnt+1.
- Counter width is ceil(log2(DEBOUNCE_CYCLES+1)); the counter never wraps.
- Latency from a clean switch edge to the stable update is 2 (sync) + DEBOUNCE_CYCLES cycles.

Reads:
- io_rdata is combinational when SwitchCtrl=1 and 16'h0000 when SwitchCtrl=0.
- Reading 0x74 with SwitchCtrl=1 returns the current chg and clears chg on that rising edge.
- If an acceptance edge coincides with a 0x74 clear, set wins and chg stays 1.
- Reads of 0x70/0x72 have no side effects.

Reset mid-debounce: the FSM returns to IDLE, the pending change is discarded, stable=0, and the change is re-detected after reset is released.

Test Plan:
- Reset LED_RESET=24'h00A5A5: assert reset_n=0 mid-cycle -> led_o=24'h00A5A5 immediately (asynchronous); SwitchCtrl=1, addr=0x70 -> io_rdata=16'h0000.
- LED write pair: LEDCtrl=1, addr=0x60, write_data=32'h1234BEEF -> led_o=24'h00BEEF after the edge; then addr=0x62, write_data=32'h000000C3 -> led_o=24'hC3BEEF; addr=0x64 write -> led_o unchanged.
- Clean switch change, DEBOUNCE_CYCLES=4: switch_i 0 -> 24'h5A1234 held.
  - Read 0x70 returns 16'h0000 until cycle 6 after the change, then 16'h1234.
  - Read 0x72 returns 16'h005A.
  - Read 0x74 returns 16'h0001.
- Bounce rejection, DEBOUNCE_CYCLES=4: toggle switch_i bit0 1/0/1 with 2-cycle spacing, then hold at 1.
  - Stable updates only 4 cycles after the final edge (plus sync delay).
  - A glitch returning to the old value leaves stable and chg unchanged.
- Clear-on-read: after chg=1, read 0x74 -> 16'h0001, next read -> 16'h0000; force an acceptance in the same cycle as a 0x74 read -> chg remains 1.
- Reset mid-COUNT: drop reset_n during COUNT -> stable=0 and chg=0; after release with the switch still held, the change is accepted DEBOUNCE_CYCLES+2 cycles later.

Source files
------------

// File: rtl/io_responder.sv
// Memory-mapped IO responder: write-only LED registers, debounced switch readback and a sticky change flag.
// LED writes land on the strobe edge; reads are combinational; switch changes settle 2+DEBOUNCE_CYCLES cycles after a clean edge.
module io_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter logic [23:0] LED_RESET       = 24'h000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        LEDCtrl,
  input  logic        SwitchCtrl,
  input  logic [7:0]  addr,
  input  logic [31:0] write_data,
  input  logic [23:0] switch_i,
  output logic [23:0] led_o,
  output logic [15:0] io_rdata
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t            state_q;
  logic [23:0]       led_q;
  logic [23:0]       sync1_q, sync2_q;
  logic [23:0]       stable_q, cand_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              chg_q;
  logic              rd_status;
  logic              unused_wdata;

  assign unused_wdata = ^write_data[31:16];
  assign rd_status    = SwitchCtrl && (addr == 8'h74);
  assign led_o        = led_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q <= LED_RESET;
    end else if (LEDCtrl) begin
      if (addr == 8'h60)      led_q[15:0]  <= write_data[15:0];
      else if (addr == 8'h62) led_q[23:16] <= write_data[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= switch_i;
      sync2_q <= sync1_q;
    end
  end

  // Bounce-back to the accepted value takes priority over restarting on a new candidate.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      chg_q    <= 1'b0;
    end else begin
      if (rd_status) chg_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q != stable_q) begin
            cand_q  <= sync2_q;
            cnt_q   <= CNT_ONE;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (sync2_q == stable_q) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= CNT_ONE;
          end else if (cnt_q >= CNT_LAST) begin
            stable_q <= cand_q;
            chg_q    <= 1'b1;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    io_rdata = 16'h0000;
    if (SwitchCtrl) begin
      case (addr)
        8'h70:   io_rdata = stable_q[15:0];
        8'h72:   io_rdata = {8'h00, stable_q[23:16]};
        8'h74:   io_rdata = {15'b0, chg_q};
        default: io_rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: stimulus queues expected LED/read values, a negedge monitor compares them.
module tb_io_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        LEDCtrl;
  logic        SwitchCtrl;
  logic [7:0]  addr;
  logic [31:0] write_data;
  logic [23:0] switch_i;
  logic [23:0] led_o;
  logic [15:0] io_rdata;

  always #5 clock = ~clock;

  io_responder #(
    .DEBOUNCE_CYCLES(4),
    .LED_RESET(24'h00A5A5)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .LEDCtrl(LEDCtrl),
    .SwitchCtrl(SwitchCtrl),
    .addr(addr),
    .write_data(write_data),
    .switch_i(switch_i),
    .led_o(led_o),
    .io_rdata(io_rdata)
  );

  typedef struct packed {
    logic        is_led;
    logic [23:0] exp;
    logic [95:0] name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [23:0] mon_got;
  int          n_chk  = 0;
  int          n_pass = 0;

  // Everything queued since the last rising edge is checked on the following falling edge.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_got = mon_e.is_led ? led_o : {8'h00, io_rdata};
      n_chk++;
      if (mon_got === mon_e.exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", mon_e.name, mon_got, mon_e.exp);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_led(input logic [23:0] v, input logic [95:0] nm);
    exp_t e;
    e.is_led = 1'b1;
    e.exp    = v;
    e.name   = nm;
    exp_q.push_back(e);
  endtask

  task automatic exp_rd(input logic [15:0] v, input logic [95:0] nm);
    exp_t e;
    e.is_led = 1'b0;
    e.exp    = {8'h00, v};
    e.name   = nm;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] v, input logic [95:0] nm);
    SwitchCtrl = 1'b1;
    addr       = a;
    exp_rd(v, nm);
  endtask

  initial begin
    reset_n    = 1'b0;
    LEDCtrl    = 1'b0;
    SwitchCtrl = 1'b0;
    addr       = 8'h00;
    write_data = 32'h0;
    switch_i   = 24'h0;
    cyc();
    cyc();
    rd(8'h70, 16'h0000, "rst_rd70");
    exp_led(24'h00A5A5, "rst_led");
    cyc();

    // LED writes, ignored address, simultaneous write and read
    reset_n    = 1'b1;
    SwitchCtrl = 1'b0;
    LEDCtrl    = 1'b1;
    addr       = 8'h60;
    write_data = 32'h1234BEEF;
    cyc();
    addr       = 8'h62;
    write_data = 32'h000000C3;
    exp_led(24'h00BEEF, "led_lo");
    cyc();
    addr       = 8'h64;
    write_data = 32'hFFFFFFFF;
    exp_led(24'hC3BEEF, "led_hi");
    cyc();
    addr       = 8'h60;
    write_data = 32'h00001111;
    SwitchCtrl = 1'b1;
    exp_rd(16'h0000, "wr_rd60");
    exp_led(24'hC3BEEF, "led_ign64");
    cyc();
    LEDCtrl    = 1'b0;
    SwitchCtrl = 1'b0;
    exp_led(24'hC31111, "led_wrrd");
    cyc();

    // Asynchronous reset asserted mid-cycle
    reset_n = 1'b0;
    exp_led(24'h00A5A5, "async_rst");
    cyc();
    reset_n = 1'b1;

    // Clean switch change
    switch_i = 24'h5A1234;
    for (int i = 0; i <= 6; i++) begin
      rd(8'h70, (i < 6) ? 16'h0000 : 16'h1234, "clean70");
      cyc();
    end
    rd(8'h72, 16'h005A, "rd72");
    cyc();
    rd(8'h74, 16'h0001, "chg_set");
    cyc();
    rd(8'h74, 16'h0000, "chg_clr");
    cyc();
    SwitchCtrl = 1'b0;
    addr       = 8'h70;
    exp_rd(16'h0000, "rd_gated");
    cyc();

    // Bounce on bit0: 1 for 2 cycles, 0 for 2 cycles, then held at 1
    for (int i = 0; i <= 10; i++) begin
      switch_i = (i < 2) ? 24'h5A1235 : (i < 4) ? 24'h5A1234 : 24'h5A1235;
      if (i == 6) rd(8'h74, 16'h0000, "glitch_chg");
      else        rd(8'h70, (i >= 10) ? 16'h1235 : 16'h1234, "bounce70");
      cyc();
    end
    rd(8'h74, 16'h0001, "bounce_chg");
    cyc();

    // Acceptance coinciding with a status read: the set wins
    switch_i = 24'h5A1234;
    for (int i = 0; i <= 8; i++) begin
      if (i < 5)       rd(8'h70, 16'h1235, "coin70");
      else if (i == 5) rd(8'h74, 16'h0000, "coin_rd");
      else if (i == 6) rd(8'h74, 16'h0001, "coin_keep");
      else if (i == 7) rd(8'h74, 16'h0000, "coin_clr");
      else             rd(8'h70, 16'h1234, "coin_new");
      cyc();
    end

    // Reset while counting, then re-detection after release
    switch_i = 24'h5A1235;
    for (int i = 0; i <= 11; i++) begin
      if (i == 3) reset_n = 1'b0;
      if (i == 5) reset_n = 1'b1;
      if (i == 4)      rd(8'h74, 16'h0000, "rst_chg");
      else if (i < 3)  rd(8'h70, 16'h1234, "pre_rst70");
      else if (i < 11) rd(8'h70, 16'h0000, "rst_stable");
      else             rd(8'h70, 16'h1235, "reaccept");
      cyc();
    end
    rd(8'h74, 16'h0001, "rst_reacc");
    cyc();
    SwitchCtrl = 1'b0;
    cyc();

    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
